mini_fetch: RTL
===============

Name: mini_fetch

Overview:
- Instruction fetch stage of the mini CPU, directly upstream of the combinational 256x16 instruction memory.
- Owns the program counter, drives the imem address, and captures the returned 16-bit word into a small instruction queue.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts redirects (JMP resolution) from execute and flushes wrong-path entries.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- QDEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch permitted this cycle; 0 freezes PC and pushes.
- imem_addr  out  8  address to imem; equals the PC register (combinational from the register).
- imem_data  in  16  instruction word returned combinationally for imem_addr.
- if_valid  out  1  queue head holds a valid instruction.
- if_instr  out  16  head instruction; format opcode[15:12], rd[11:10], rs[9:8], imm[7:0].
- if_pc  out  8  address of head instruction.
- if_jmp_pred  out  1  head entry was redirected early (see Optional Feature).
- id_ready  in  1  decode accepts head this cycle.
- redirect_valid  in  1  execute requests PC redirect.
- redirect_pc  in  8  redirect target.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; queue count = 0; read/write pointers = 0.
  - if_valid = 0; if_instr = 16'h0000; if_pc = 8'h00; if_jmp_pred = 0.
- Outputs come from the registered queue head. When empty: if_instr = 0, if_pc = 0, if_jmp_pred = 0.
- pop = if_valid && id_ready. push = fetch_en && !redirect_valid && (count < QDEPTH || pop).
- push:
  - Write {pc, imem_data, pred flag} at the write pointer.
  - pc <= pc + 1, modulo 256: 8'hFF wraps to 8'h00.
- Push and pop in the same cycle:
  - Count unchanged.
  - Allowed when full: the popped slot frees space the same cycle.
  - Allowed when QDEPTH-1 entries are held.
- Full with no pop: no push; pc holds.
- Empty: if_valid = 0 and id_ready is ignored. A word pushed in cycle N is visible at the head in cycle N+1 (1-cycle fetch-to-decode latency).
- redirect_valid has highest priority:
  - Count <= 0, pointers <= 0, pc <= redirect_pc.
  - No push or pop that cycle; if_valid drops to 0 the next cycle.
  - The first target word is pushed in the cycle after the redirect and is valid 2 cycles after redirect_valid.
- Back-to-back redirects: the last one wins; the queue stays empty throughout.
- fetch_en = 0: pc and pushes freeze; pops continue to drain the queue.
- Queue entries are never modified after write. Ordering is strictly FIFO.

Optional Feature:
- Macro: MINI_FETCH_EARLY_JMP_EN.
- Enabled:
  - On a push whose imem_data[15:12] == 4'h7 (JMP), pc <= imem_data[7:0] instead of pc+1.
  - The entry is stored with pred flag = 1; the JMP is still delivered to decode.
  - Execute then must not redirect for a predicted JMP.
  - redirect_valid still overrides the early JMP in the same cycle.
- Disabled: pc always increments on push; if_jmp_pred is constant 0; JMPs rely on redirect from execute.

Test Plan:
- Reset and streaming: program 0x1005, 0x1403, 0x2100, 0x6010, 0x5810, 0x4900, 0x7002 at addresses 00-06; rst pulse, fetch_en = 1, id_ready = 1.
  - Required: if_valid rises 1 cycle after reset release.
  - if_pc/if_instr sequence: 00/1005, 01/1403, 02/2100, ... with one instruction per cycle.
- Backpressure: id_ready = 0 for 4 cycles after the first valid.
  - Queue fills to 2; imem_addr holds at 8'h02; head stays 00/1005.
  - Releasing id_ready resumes 01/1403 then 02/2100 with no loss or duplication.
- Redirect flush: with entries queued, assert redirect_valid for 1 cycle with redirect_pc = 8'h02.
  - Next cycle: if_valid = 0, imem_addr = 02.
  - Following cycle: head = 02/2100.
- Asynchronous reset mid-stream: assert rst between clock edges while the queue is full.
  - Required: if_valid = 0, imem_addr = 00 and if_instr = 0 immediately, before the next edge.
- Early JMP (macro on): on fetching 06/7002, the next imem_addr is 8'h02 rather than 8'h07.
  - Decode sees 06/7002 with if_jmp_pred = 1, then 02/2100.
  - With the macro off: the next address is 07, if_jmp_pred = 0, and imem returns 0000.
- PC wrap and fetch_en: set redirect_pc = 8'hFE, then stream.
  - Required: addresses FE, FF, 00.
  - Dropping fetch_en for 3 cycles freezes imem_addr while the queue drains to empty.

Source files
------------

// File: rtl/mini_fetch.sv
// mini_fetch: instruction fetch stage of the mini CPU.
// Owns the PC and drives the combinational imem address. Fetched words are
// kept in a small FIFO whose head is presented to decode.
// Optional feature: define MINI_FETCH_EARLY_JMP_EN to steer the PC to the
// target of a JMP (opcode 4'h7) in the same cycle the JMP is fetched.
module mini_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [7:0]  if_pc,
  output logic        if_jmp_pred,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc
);

  localparam int PW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    pc_q, pc_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [15:0] instrMem_q [QDEPTH];
  logic [7:0]  pcMem_q    [QDEPTH];
  logic        predMem_q  [QDEPTH];

  logic pop;
  logic push;
  logic notFull;
  logic isJmp;

`ifdef MINI_FETCH_EARLY_JMP_EN
  assign isJmp = (imem_data[15:12] == 4'h7);
`else
  assign isJmp = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != '0);
  assign notFull   = (count_q < CW'(QDEPTH));
  assign pop       = if_valid && id_ready;
  assign push      = fetch_en && !redirect_valid && (notFull || pop);

  assign if_instr    = if_valid ? instrMem_q[rptr_q] : 16'h0000;
  assign if_pc       = if_valid ? pcMem_q[rptr_q]    : 8'h00;
  assign if_jmp_pred = if_valid ? predMem_q[rptr_q]  : 1'b0;

  // Next PC, pointers and occupancy; a redirect flushes everything and wins over push/pop
  always_comb begin
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push) begin
        wptr_d = wptr_q + PW'(1);
        pc_d   = isJmp ? imem_data[7:0] : pc_q + 8'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: PC, FIFO pointers and entry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage: an entry is written once on push and never touched again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        instrMem_q[i] <= 16'h0000;
        pcMem_q[i]    <= 8'h00;
        predMem_q[i]  <= 1'b0;
      end
    end else if (push) begin
      instrMem_q[wptr_q] <= imem_data;
      pcMem_q[wptr_q]    <= pc_q;
      predMem_q[wptr_q]  <= isJmp;
    end
  end

endmodule
